// File: rtl/exec_stage_if.sv
// Issue/writeback bundle between the control unit, exec_stage and reg_file's write port.
// The slave side is the execute stage; the master side is whoever issues ops and observes writes.
interface exec_stage_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    dest;
  logic             busy;
  logic             regwrite;
  logic [AW-1:0]    wr;
  logic [WIDTH-1:0] wd;
  logic             overflow;

  modport master (
    output start, op, a, b, dest,
    input  busy, regwrite, wr, wd, overflow
  );

  modport slave (
    input  start, op, a, b, dest,
    output busy, regwrite, wr, wd, overflow
  );
endinterface

// File: rtl/exec_stage.sv
// Execute/writeback stage: single-cycle ALU ops plus an unsigned shift-add multiply
// over WIDTH cycles, returning results through reg_file's write port.
module exec_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  exec_stage_if.slave   ex
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL_RUN, WRITE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] a_shift_q, a_shift_d;
  logic [WIDTH-1:0]   b_reg_q, b_reg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      dest_q, dest_d;
  logic               regwrite_q, regwrite_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   sum, diff;
  logic [2*WIDTH-1:0] acc_sum;
  logic signed [WIDTH-1:0] sa, sb;

  // Signed overflow: operands (b inverted for subtract) agree in sign, result does not.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign sum     = ex.a + ex.b;
  assign diff    = ex.a - ex.b;
  assign sa      = ex.a;
  assign sb      = ex.b;
  assign acc_sum = acc_q + (b_reg_q[0] ? a_shift_q : '0);

  always_comb begin
    state_d    = state_q;
    a_shift_d  = a_shift_q;
    b_reg_d    = b_reg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    regwrite_d = 1'b0;
    wr_d       = '0;
    wd_d       = '0;
    ovf_d      = 1'b0;

    if (state_q == MUL_RUN) begin
      acc_d     = acc_sum;
      a_shift_d = {a_shift_q[2*WIDTH-2:0], 1'b0};
      b_reg_d   = {1'b0, b_reg_q[WIDTH-1:1]};
      cnt_d     = cnt_q + 1'b1;
      // The final iteration's partial product is folded straight into the write.
      if (cnt_q == LAST) begin
        state_d    = WRITE;
        regwrite_d = 1'b1;
        wr_d       = dest_q;
        wd_d       = acc_sum[WIDTH-1:0];
        ovf_d      = |acc_sum[2*WIDTH-1:WIDTH];
      end
    end else begin
      state_d = IDLE;
      if (ex.start) begin
        state_d    = WRITE;
        regwrite_d = 1'b1;
        wr_d       = ex.dest;
        case (ex.op)
          OP_ADD: begin
            wd_d  = sum;
            ovf_d = add_ovf(ex.a, ex.b, sum);
          end
          OP_SUB: begin
            wd_d  = diff;
            ovf_d = sub_ovf(ex.a, ex.b, diff);
          end
          OP_AND: wd_d = ex.a & ex.b;
          OP_OR:  wd_d = ex.a | ex.b;
          OP_XOR: wd_d = ex.a ^ ex.b;
          OP_SLT: wd_d = {{(WIDTH-1){1'b0}}, (sa < sb)};
          OP_MUL: begin
            state_d    = MUL_RUN;
            regwrite_d = 1'b0;
            wr_d       = '0;
            a_shift_d  = {{WIDTH{1'b0}}, ex.a};
            b_reg_d    = ex.b;
            acc_d      = '0;
            cnt_d      = '0;
            dest_d     = ex.dest;
          end
          default: begin
            state_d    = IDLE;
            regwrite_d = 1'b0;
            wr_d       = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_shift_q  <= '0;
      b_reg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      wr_q       <= '0;
      wd_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_shift_q  <= a_shift_d;
      b_reg_q    <= b_reg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      wr_q       <= wr_d;
      wd_q       <= wd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ex.busy     = (state_q == MUL_RUN);
  assign ex.regwrite = regwrite_q;
  assign ex.wr       = wr_q;
  assign ex.wd       = wd_q;
  assign ex.overflow = ovf_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: vector table for single-cycle ops, hand sequences
// for multiply timing, ignored start while busy, mid-op reset and back-to-back issue.
module tb_exec_stage;

  logic clk = 1'b0;
  logic reset_n;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  exec_stage_if #(.WIDTH(16), .AW(2)) bus ();

  exec_stage #(.WIDTH(16), .AW(2)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .ex      (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  dest;
    logic [15:0] wd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] d);
    bus.start = s;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dest  = d;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_regwrite"}, 32'(bus.regwrite), 32'd0);
    check({name, "_wd"},       32'(bus.wd),       32'd0);
    check({name, "_wr"},       32'(bus.wr),       32'd0);
    check({name, "_ovf"},      32'(bus.overflow), 32'd0);
  endtask

  // Issue a MUL at a negedge, then count negedges until regwrite (bounded).
  task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] d, input logic [15:0] exp_wd, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    drive(1'b1, 3'b101, a, b, d);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (!bus.regwrite && cyc < 40);
    check({name, "_latency"}, 32'(cyc), 32'd17);
    check({name, "_busy"},    32'(bus.busy), 32'd0);
    check({name, "_wr"},      32'(bus.wr), 32'(d));
    check({name, "_wd"},      32'(bus.wd), 32'(exp_wd));
    check({name, "_ovf"},     32'(bus.overflow), 32'(exp_ovf));
    @(negedge clk);
    check({name, "_rw_drop"}, 32'(bus.regwrite), 32'd0);
  endtask

  initial begin
    int seen;

    vecs[0] = '{"add_500",  3'b000, 16'd500,   16'd500,   2'd1, 16'd1000,  1'b0};
    vecs[1] = '{"add_ovf",  3'b000, 16'h7FFF,  16'h0001,  2'd2, 16'h8000,  1'b1};
    vecs[2] = '{"sub_0m1",  3'b001, 16'h0000,  16'h0001,  2'd3, 16'hFFFF,  1'b0};
    vecs[3] = '{"slt_neg",  3'b100, 16'hFFFF,  16'h0001,  2'd1, 16'h0001,  1'b0};
    vecs[4] = '{"slt_pos",  3'b100, 16'h0001,  16'hFFFF,  2'd2, 16'h0000,  1'b0};
    vecs[5] = '{"xor",      3'b110, 16'h00FF,  16'h0F0F,  2'd3, 16'h0FF0,  1'b0};
    vecs[6] = '{"and",      3'b010, 16'hF0F0,  16'hFF00,  2'd1, 16'hF000,  1'b0};
    vecs[7] = '{"or",       3'b011, 16'h00F0,  16'h0F00,  2'd2, 16'h0FF0,  1'b0};
    vecs[8] = '{"sub_ovf",  3'b001, 16'h8000,  16'h0001,  2'd3, 16'h7FFF,  1'b1};
    vecs[9] = '{"add_wrap", 3'b000, 16'hFFFF,  16'h0001,  2'd0, 16'h0000,  1'b0};

    reset_n = 1'b0;
    drive(1'b0, 3'b111, 16'd0, 16'd0, 2'd0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;

    // Single-cycle ops, each followed by an idle cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      @(negedge clk);
      bus.start = 1'b0;
      check({vecs[i].name, "_rw"},  32'(bus.regwrite), 32'd1);
      check({vecs[i].name, "_wr"},  32'(bus.wr),       32'(vecs[i].dest));
      check({vecs[i].name, "_wd"},  32'(bus.wd),       32'(vecs[i].wd));
      check({vecs[i].name, "_ovf"}, 32'(bus.overflow), 32'(vecs[i].ovf));
      @(negedge clk);
      check_idle_outputs({vecs[i].name, "_after"});
    end

    // MUL 300*200 with a stray start pulse while busy.
    @(negedge clk);
    drive(1'b1, 3'b101, 16'd300, 16'd200, 2'd2);
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 5) drive(1'b1, 3'b000, 16'd1, 16'd1, 2'd1);
      if (i == 6) bus.start = 1'b0;
      check($sformatf("mul1_busy_c%0d", i), 32'(bus.busy), 32'd1);
      check($sformatf("mul1_rw_c%0d", i),   32'(bus.regwrite), 32'd0);
    end
    @(negedge clk);
    check("mul1_busy_end", 32'(bus.busy), 32'd0);
    check("mul1_rw",  32'(bus.regwrite), 32'd1);
    check("mul1_wr",  32'(bus.wr), 32'd2);
    check("mul1_wd",  32'(bus.wd), 32'd60000);
    check("mul1_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    check("mul1_no_queue", 32'(bus.regwrite), 32'd0);

    run_mul("mul2", 16'd500, 16'd500, 2'd3, 16'd53392, 1'b1);
    run_mul("mul3", 16'hFFFF, 16'h0001, 2'd0, 16'hFFFF, 1'b0);

    // Reset in the middle of a MUL.
    @(negedge clk);
    drive(1'b1, 3'b101, 16'd300, 16'd200, 2'd1);
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_idle_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.regwrite || bus.busy) seen++;
    end
    check("rst_no_write", 32'(seen), 32'd0);
    drive(1'b1, 3'b000, 16'd1, 16'd2, 2'd3);
    @(negedge clk);
    bus.start = 1'b0;
    check("post_rst_rw", 32'(bus.regwrite), 32'd1);
    check("post_rst_wr", 32'(bus.wr), 32'd3);
    check("post_rst_wd", 32'(bus.wd), 32'd3);

    // Back-to-back ADD, OR, NOP.
    @(negedge clk);
    drive(1'b1, 3'b000, 16'd5, 16'd6, 2'd1);
    @(negedge clk);
    drive(1'b1, 3'b011, 16'h0F00, 16'h00F0, 2'd2);
    check("b2b_add_rw", 32'(bus.regwrite), 32'd1);
    check("b2b_add_wr", 32'(bus.wr), 32'd1);
    check("b2b_add_wd", 32'(bus.wd), 32'd11);
    @(negedge clk);
    drive(1'b1, 3'b111, 16'h1234, 16'h4321, 2'd3);
    check("b2b_or_rw", 32'(bus.regwrite), 32'd1);
    check("b2b_or_wr", 32'(bus.wr), 32'd2);
    check("b2b_or_wd", 32'(bus.wd), 32'h0FF0);
    @(negedge clk);
    bus.start = 1'b0;
    check_idle_outputs("b2b_nop");
    @(negedge clk);
    check_idle_outputs("b2b_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
